// File: rtl/sseg_pkg.sv
// Shared types and constants for the 4-digit seven-segment scan controller.
package sseg_pkg;

  typedef logic [3:0] bcd_t;
  typedef enum logic [1:0] {IDLE, CONVERT, LATCH} conv_state_t;

  localparam int NUM_DIGITS = 4;

  // Active-low cathodes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_LUT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [6:0] seg_encode(input bcd_t d);
    return (d <= 4'd9) ? SEG_LUT[d] : SEG_BLANK;
  endfunction

  // Double-dabble correction applied before each shift
  function automatic bcd_t dd_adj(input bcd_t n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per clock, VAL_W shifts, then a one-cycle LATCH with done high.
module bin2bcd_seq
  import sseg_pkg::*;
#(
  parameter int VAL_W = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [VAL_W-1:0]            value,
  output logic                        busy,
  output logic                        done,
  output bcd_t [NUM_DIGITS-1:0]       bcd
);

  localparam int CNT_W = (VAL_W > 1) ? $clog2(VAL_W) : 1;

  conv_state_t              state, state_nxt;
  logic [VAL_W-1:0]         sh_bin;
  bcd_t [NUM_DIGITS-1:0]    sh_bcd, adj;
  logic [CNT_W-1:0]         cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONVERT;
      CONVERT: if (cnt == CNT_W'(VAL_W-1)) state_nxt = LATCH;
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == LATCH);
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    assign adj[i] = dd_adj(sh_bcd[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_bin <= '0;
      sh_bcd <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sh_bin <= value;
          sh_bcd <= '0;
          cnt    <= '0;
        end
        CONVERT: begin
          {sh_bcd, sh_bin} <= {adj, sh_bin} << 1;
          cnt              <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bcd = sh_bcd;

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Basys3 display sequencer: binary-to-BCD with a 1-deep pending slot, leading-zero blanking, digit scan.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int VAL_W      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [VAL_W-1:0] value,
  input  logic             value_valid,
  output logic             busy,
  output logic [3:0]       sseg_an,
  output logic [6:0]       sseg_char
);

  localparam int TC = CLK_HZ / REFRESH_HZ - 1;
  localparam int PW = (TC > 0) ? $clog2(TC + 1) : 1;

  logic                   conv_busy, conv_done, start, pend;
  logic [VAL_W-1:0]       pend_val, start_val;
  bcd_t [NUM_DIGITS-1:0]  conv_bcd, disp;
  logic [PW-1:0]          presc;
  logic [1:0]             idx;
  logic                   tick;
  logic [NUM_DIGITS-1:0]  nz;
  logic [6:0]             cur_char;

  // A fresh strobe beats a parked one: latest value wins.
  assign start     = !conv_busy && (value_valid || pend);
  assign start_val = value_valid ? value : pend_val;
  assign busy      = conv_busy;

  bin2bcd_seq #(.VAL_W(VAL_W)) u_b2b (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .value (start_val),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pend     <= 1'b0;
      pend_val <= '0;
      disp     <= '0;
    end else begin
      if (start) pend <= 1'b0;
      else if (value_valid) begin
        pend     <= 1'b1;
        pend_val <= value;
      end
      if (conv_done) disp <= conv_bcd;
    end
  end

  assign tick = (presc == PW'(TC));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx + 1'b1;
    end
  end

  // nz[i]: digit i or any higher digit is non-zero
  always_comb begin
    nz = '0;
    nz[NUM_DIGITS-1] = |disp[NUM_DIGITS-1];
    for (int i = NUM_DIGITS - 2; i >= 0; i--) nz[i] = nz[i+1] | (|disp[i]);
  end

  assign cur_char = (idx != 2'd0 && !nz[idx]) ? SEG_BLANK : seg_encode(disp[idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sseg_an   <= 4'hF;
      sseg_char <= SEG_BLANK;
    end else if (tick) begin
      sseg_an   <= ~(4'b0001 << idx);
      sseg_char <= cur_char;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized + directed bench for sseg_scan_ctrl, checked every cycle against a decimal-level model.
module tb_sseg_scan_ctrl;

  localparam int VW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          value_valid = 1'b0;
  logic [VW-1:0] value = '0;
  logic          busy;
  logic [3:0]    sseg_an;
  logic [6:0]    sseg_char;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sseg_scan_ctrl #(.CLK_HZ(1000), .REFRESH_HZ(250), .VAL_W(VW)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .sseg_an     (sseg_an),
    .sseg_char   (sseg_char)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30; 4: return 7'h19;
      5: return 7'h12; 6: return 7'h02; 7: return 7'h78; 8: return 7'h00; 9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Decimal digit i of n, blank when it and everything above is zero (digit 0 never blank)
  function automatic logic [6:0] digit_char(input int n, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (i > 0 && n / p == 0) return 7'h7F;
    return seg_of((n / p) % 10);
  endfunction

  // Model: edge count since reset, one conversion in flight, one parked value, shown value.
  int         m_n, m_remain, m_cval, m_pval, m_disp, m_d;
  bit         m_active, m_pend, m_ok;
  logic [3:0] m_an;
  logic [6:0] m_char;

  initial begin
    m_ok = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_n = 0; m_active = 0; m_remain = 0; m_pend = 0; m_pval = 0; m_disp = 0;
        m_an = 4'hF; m_char = 7'h7F; m_ok = 1;
      end else if (m_ok) begin
        m_n++;
        if (m_n % 4 == 0) begin
          m_d    = (m_n / 4 - 1) % 4;
          m_an   = ~(4'b0001 << m_d);
          m_char = digit_char(m_disp, m_d);
        end
        if (m_active) begin
          m_remain--;
          if (m_remain == 0) begin
            m_disp   = m_cval;
            m_active = 0;
          end
          if (value_valid) begin
            m_pend = 1;
            m_pval = int'(value);
          end
        end else if (value_valid || m_pend) begin
          m_cval   = value_valid ? int'(value) : m_pval;
          m_pend   = 0;
          m_active = 1;
          m_remain = VW + 1;
        end
      end
      #1;
      if (m_ok) begin
        check("busy", busy, m_active);
        check("an", sseg_an, m_an);
        check("char", sseg_char, m_char);
      end
    end
  end

  task automatic strobe(input int v);
    @(negedge clk);
    value_valid = 1'b1;
    value       = VW'(v);
    @(negedge clk);
    value_valid = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] tgt);
    int k = 0;
    while (sseg_an !== tgt && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("wait_an", sseg_an, tgt);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic show_digits(input logic [6:0] c0, input logic [6:0] c1,
                             input logic [6:0] c2, input logic [6:0] c3);
    wait_an(4'b1110); check("dig0", sseg_char, c0);
    wait_an(4'b1101); check("dig1", sseg_char, c1);
    wait_an(4'b1011); check("dig2", sseg_char, c2);
    wait_an(4'b0111); check("dig3", sseg_char, c3);
  endtask

  initial begin
    int c;
    logic [3:0] seq [5];
    logic [3:0] prev;
    seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_an", sseg_an, 4'hF);
    check("rst_char", sseg_char, 7'h7F);
    check("rst_busy", busy, 1'b0);
    @(negedge clk); @(negedge clk);
    check("pre_tick_an", sseg_an, 4'hF);
    show_digits(7'h40, 7'h7F, 7'h7F, 7'h7F);

    // 1023: busy for VAL_W+1 cycles, then "1023"
    strobe(1023);
    c = 0;
    while (busy && c < 50) begin c++; @(negedge clk); end
    check("busy_len", c, 11);
    repeat (16) @(negedge clk);
    show_digits(7'h30, 7'h24, 7'h40, 7'h79);

    strobe(7);
    wait_idle();
    repeat (16) @(negedge clk);
    show_digits(7'h78, 7'h7F, 7'h7F, 7'h7F);

    // 512 is overwritten in the pending slot by 5
    strobe(100);
    @(negedge clk);
    strobe(512);
    strobe(5);
    wait_idle();
    @(negedge clk);
    check("pend_restart", busy, 1'b1);
    wait_idle();
    repeat (16) @(negedge clk);
    show_digits(7'h12, 7'h7F, 7'h7F, 7'h7F);

    // reset mid-conversion
    strobe(999);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_an", sseg_an, 4'hF);
    check("midrst_char", sseg_char, 7'h7F);
    check("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    show_digits(7'h40, 7'h7F, 7'h7F, 7'h7F);

    // scan wrap with exact 4-cycle spacing
    wait_an(4'b1110);
    for (int j = 1; j < 5; j++) begin
      prev = sseg_an;
      c = 0;
      while (sseg_an === prev && c < 20) begin @(negedge clk); c++; end
      check("scan_gap", c, 4);
      check("scan_seq", sseg_an, seq[j]);
    end

    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 399) == 0);
      value_valid = ($urandom_range(0, 9) == 0);
      value       = VW'($urandom_range(0, 1023));
    end
    @(negedge clk);
    rst = 1'b0;
    value_valid = 1'b0;
    repeat (30) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
